// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues in-order fetches under a credit limit, buffers responses
// for decode and discards responses belonging to fetches squashed by a redirect.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] IFaddr,
   output logic        IFreq,
   input  logic        IFgnt,
   input  logic        IFrvalid,
   input  logic [31:0] IFrdata,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic [31:0] FQinstr,
   output logic [31:0] FQpc,
   output logic        FQvalid,
   input  logic        FQready
);

   localparam int unsigned CntW = $clog2(DEPTH + 1);
   localparam int unsigned PtrW = $clog2(DEPTH);
   localparam logic [CntW:0] DepthC = DEPTH[CntW:0];

   typedef enum logic [1:0] {StFetch, StFull, StFlush} state_e;

   state_e          state_q, state_d;
   logic [31:0]     pc_q, pc_d;
   logic [CntW-1:0] count_q, count_d;
   logic [CntW-1:0] outst_q, outst_d;
   logic [CntW-1:0] drop_q, drop_d;
   logic [PtrW-1:0] head_q, head_d;
   logic [PtrW-1:0] tail_q, tail_d;
   logic            run_q;

   logic [31:0]     instr_mem [DEPTH];
   logic [31:0]     pc_mem    [DEPTH];

   logic [CntW:0]   credit_used;
   logic            credit_ok;
   logic            grant;
   logic            push;
   logic            pop;
   logic [31:0]     resp_pc;

   assign FQvalid = (count_q != '0);
   // Storage is not reset; mask the head so the outputs read zero while empty.
   assign FQinstr = FQvalid ? instr_mem[head_q] : '0;
   assign FQpc    = FQvalid ? pc_mem[head_q]    : '0;
   assign IFaddr  = pc_q;

   always_comb begin
      credit_used = {1'b0, count_q} + {1'b0, outst_q};
      credit_ok   = (credit_used < DepthC);
      IFreq       = run_q && !redirect && (state_q == StFetch) && credit_ok;
      grant       = IFreq && IFgnt;
      push        = IFrvalid && (drop_q == '0) && !redirect;
      pop         = FQvalid && FQready && !redirect;
      // Live fetches are consecutive words, so the oldest one is outst_q words behind pc_q.
      resp_pc     = pc_q - (32'(outst_q) << 2);

      state_d = state_q;
      pc_d    = grant ? pc_q + 32'd4 : pc_q;
      outst_d = outst_q + CntW'(grant) - CntW'(IFrvalid);
      drop_d  = (IFrvalid && (drop_q != '0)) ? drop_q - CntW'(1) : drop_q;
      count_d = count_q + CntW'(push) - CntW'(pop);
      head_d  = pop  ? head_q + PtrW'(1) : head_q;
      tail_d  = push ? tail_q + PtrW'(1) : tail_q;

      if (redirect) begin
         pc_d    = {redirect_pc[31:2], 2'b00};
         count_d = '0;
         head_d  = '0;
         tail_d  = '0;
         drop_d  = outst_q - CntW'(IFrvalid);
         state_d = (drop_d == '0) ? StFetch : StFlush;
      end else begin
         unique case (state_q)
            StFetch: if (!credit_ok && !pop) state_d = StFull;
            StFull:  if (pop) state_d = StFetch;
            StFlush: if (drop_d == '0) state_d = StFetch;
            default: state_d = StFetch;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StFetch;
         pc_q    <= RESET_PC;
         count_q <= '0;
         outst_q <= '0;
         drop_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
         outst_q <= outst_d;
         drop_q  <= drop_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         run_q   <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[tail_q] <= IFrdata;
         pc_mem[tail_q]    <= resp_pc;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, checked against a
// queue-based model of fetches in flight and entries awaiting decode.
module tb_fetch_queue;

   localparam int unsigned Depth   = 4;
   localparam logic [31:0] ResetPc = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] IFaddr;
   logic        IFreq;
   logic        IFgnt;
   logic        IFrvalid;
   logic [31:0] IFrdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [31:0] FQinstr;
   logic [31:0] FQpc;
   logic        FQvalid;
   logic        FQready;

   fetch_queue #(
      .DEPTH   (Depth),
      .RESET_PC(ResetPc)
   ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .IFaddr     (IFaddr),
      .IFreq      (IFreq),
      .IFgnt      (IFgnt),
      .IFrvalid   (IFrvalid),
      .IFrdata    (IFrdata),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .FQinstr    (FQinstr),
      .FQpc       (FQpc),
      .FQvalid    (FQvalid),
      .FQready    (FQready)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] addr;
      bit          live;
      int          gcyc;
   } fetch_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

   fetch_t      mem_q[$];
   entry_t      ref_q[$];
   logic [31:0] exp_pc;
   int          cyc;
   int          n_checks;
   int          n_errors;
   int          obs_grants;
   int          obs_pops;
   logic [31:0] last_gnt_addr;
   logic [31:0] first_pc;
   bit          first_seen;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Called at posedge+1; drives one cycle, checks at negedge, advances the model.
   task automatic step(input bit gnt, input bit rdy, input bit redir, input logic [31:0] tgt,
                       input bit rsp_en);
      bit     rsp;
      bit     exp_req;
      bit     exp_valid;
      int     dead;
      fetch_t f;
      IFgnt       = gnt;
      FQready     = rdy;
      redirect    = redir;
      redirect_pc = tgt;
      rsp         = rsp_en && (mem_q.size() > 0) && (mem_q[0].gcyc < cyc);
      IFrvalid    = rsp;
      IFrdata     = rsp ? instr_of(mem_q[0].addr) : 32'hDEAD_BEEF;
      @(negedge clk);
      dead = 0;
      foreach (mem_q[i]) if (!mem_q[i].live) dead++;
      exp_req   = !redir && (dead == 0) && ((ref_q.size() + mem_q.size()) < Depth);
      exp_valid = (ref_q.size() != 0);
      check_eq("ifreq", IFreq, exp_req);
      check_eq("ifaddr", IFaddr, exp_pc);
      check_eq("fqvalid", FQvalid, exp_valid);
      if (exp_valid) begin
         check_eq("fqpc", FQpc, ref_q[0].pc);
         check_eq("fqinstr", FQinstr, ref_q[0].instr);
      end
      if (IFreq && gnt) begin
         obs_grants++;
         last_gnt_addr = IFaddr;
      end
      if (FQvalid && !first_seen) begin
         first_seen = 1'b1;
         first_pc   = FQpc;
      end
      if (FQvalid && rdy && !redir) obs_pops++;
      if (exp_valid && rdy && !redir) void'(ref_q.pop_front());
      if (rsp) begin
         f = mem_q.pop_front();
         if (f.live && !redir) ref_q.push_back('{instr: instr_of(f.addr), pc: f.addr});
      end
      if (exp_req && gnt) begin
         mem_q.push_back('{addr: exp_pc, live: 1'b1, gcyc: cyc});
         exp_pc += 32'd4;
      end
      if (redir) begin
         ref_q.delete();
         foreach (mem_q[i]) mem_q[i].live = 1'b0;
         exp_pc = {tgt[31:2], 2'b00};
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      IFgnt       = 1'b0;
      FQready     = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      IFrvalid    = 1'b0;
      IFrdata     = '0;
      #2 reset = 1'b0;
      #1;
      check_eq("rst_ifreq", IFreq, 0);
      check_eq("rst_ifaddr", IFaddr, ResetPc);
      check_eq("rst_fqvalid", FQvalid, 0);
      check_eq("rst_fqinstr", FQinstr, 0);
      check_eq("rst_fqpc", FQpc, 0);
      mem_q.delete();
      ref_q.delete();
      exp_pc = ResetPc;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      first_seen = 1'b0;
   endtask

   initial begin
      reset       = 1'b0;
      IFgnt       = 1'b0;
      FQready     = 1'b0;
      redirect    = 1'b0;
      redirect_pc = '0;
      IFrvalid    = 1'b0;
      IFrdata     = '0;
      n_checks    = 0;
      n_errors    = 0;
      cyc         = 0;
      exp_pc      = ResetPc;

      // Streaming: one word per cycle with 1-cycle memory.
      do_reset();
      obs_pops = 0;
      repeat (12) step(1, 1, 0, '0, 1);
      check_eq("stream_pops", obs_pops, 10);

      // Decode stalled: credits run out after DEPTH grants, one pop frees exactly one.
      do_reset();
      obs_grants = 0;
      repeat (8) step(1, 0, 0, '0, 1);
      check_eq("full_grants", obs_grants, 4);
      obs_grants = 0;
      step(1, 1, 0, '0, 1);
      repeat (5) step(1, 0, 0, '0, 1);
      check_eq("refill_grants", obs_grants, 1);
      check_eq("refill_addr", last_gnt_addr, 32'h10);

      // Grant withheld: request and address held stable.
      do_reset();
      step(1, 1, 0, '0, 1);
      step(1, 1, 0, '0, 1);
      repeat (3) begin
         step(0, 1, 0, '0, 1);
         check_eq("stall_addr", IFaddr, 32'h8);
         check_eq("stall_req", IFreq, 1);
      end
      step(1, 1, 0, '0, 1);
      check_eq("post_grant_addr", IFaddr, 32'hC);

      // Redirect with two fetches outstanding and an unaligned target.
      do_reset();
      step(1, 0, 0, '0, 0);
      step(1, 0, 0, '0, 1);
      step(1, 0, 0, '0, 0);
      step(1, 0, 1, 32'h103, 0);
      check_eq("redir_empty", FQvalid, 0);
      first_seen = 1'b0;
      repeat (6) step(1, 1, 0, '0, 1);
      check_eq("redir_seen", first_seen, 1);
      check_eq("redir_first_pc", first_pc, 32'h100);

      // Redirect coinciding with a response and a pop.
      do_reset();
      step(1, 0, 0, '0, 0);
      step(1, 0, 0, '0, 1);
      step(1, 0, 0, '0, 0);
      step(1, 1, 1, 32'h200, 1);
      check_eq("redir_rsp_empty", FQvalid, 0);
      step(1, 1, 0, '0, 0);
      check_eq("drop_hold_req", IFreq, 0);
      step(1, 1, 0, '0, 1);
      check_eq("drop_done_req", IFreq, 1);
      check_eq("drop_done_addr", IFaddr, 32'h200);
      repeat (4) step(1, 1, 0, '0, 1);

      // Reset while full with three fetches outstanding.
      do_reset();
      step(1, 0, 0, '0, 0);
      step(1, 0, 0, '0, 1);
      step(1, 0, 0, '0, 0);
      step(1, 0, 0, '0, 0);
      step(1, 0, 0, '0, 0);
      check_eq("pre_rst_valid", FQvalid, 1);
      do_reset();
      repeat (6) step(1, 1, 0, '0, 1);

      // Random traffic.
      do_reset();
      repeat (3000) begin
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
              $urandom_range(0, 15) == 0, $urandom, $urandom_range(0, 1) != 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
